weight_fetch_unit: RTL and testbench
====================================

// Module: weight_fetch_unit
// PURPOSE
//  Parametrised weight fetch engine that sits between the accelerator controller and the memory arbiter.
//  Per start, reads one output channel's 3x3 weight block and then, if enabled, its 1x1 block.
//  Multiple reads are kept in flight up to a bounded limit; responses are streamed into the MAC weight buffer with decoded write addresses.
// PARAMETERS
//  ADDR_W     32  bus address width
//  DATA_W     32  bus/weight-buffer data width
//  K3_WORDS   72  DATA_W words per out-channel 3x3 block
//  K1_WORDS    8  DATA_W words per out-channel 1x1 block
//  MAX_OUTST   4  max issued-but-unanswered reads (1..15)
//  IDX_W       7  word-index width, must be >= clog2(K3_WORDS)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       synchronous active-low reset
//  start      in   1       launch fetch; sampled only when busy=0
//  k1_en      in   1       fetch 1x1 block after 3x3; latched at start
//  out_ch     in   8       output channel index; latched at start
//  w3_base    in   ADDR_W  3x3 region byte base; latched at start
//  w1_base    in   ADDR_W  1x1 region byte base; latched at start
//  busy       out  1       high from cycle after accepted start until done
//  done       out  1       one-cycle pulse, last response written
//  req_addr   out  ADDR_W  read byte address to arbiter
//  req_vld    out  1       read request valid
//  req_rdy    in   1       arbiter accepts request when req_vld&req_rdy
//  rsp_data   in   DATA_W  read data
//  rsp_vld    in   1       read data valid (in-order returns)
//  rsp_rdy    out  1       always 1 while busy, 0 otherwise
//  wr_en      out  1       weight-buffer write strobe = rsp_vld&rsp_rdy
//  wr_addr    out  9+IDX_W {sel(1),out_ch(8),word_idx(IDX_W)}; sel 0=3x3, 1=1x1
//  wr_data    out  DATA_W  = rsp_data
// BEHAVIOUR
//  Reset: busy,done,req_vld,rsp_rdy=0; req_addr=0; all counters 0; FSM=IDLE.
//  FSM: IDLE -start-> REQ3 -last 3x3 issue-> REQ1 (k1_en) or DRAIN (!k1_en);
//   REQ1 -last 1x1 issue-> DRAIN; DRAIN -all responses received-> IDLE with done=1 that cycle.
//  Addresses: 3x3 word i = w3_base + out_ch*K3_WORDS*(DATA_W/8) + i*(DATA_W/8);
//   1x1 word j = w1_base + out_ch*K1_WORDS*(DATA_W/8) + j*(DATA_W/8). Arithmetic modulo 2^ADDR_W.
//  req_addr/req_vld are registered; first request is valid 1 cycle after start.
//  req_vld held with stable req_addr until req_rdy; never dropped without handshake.
//  Outstanding counter: +1 on req handshake, -1 on rsp handshake, unchanged if both same cycle.
//  req_vld=0 while outstanding==MAX_OUTST (unless a response is accepted that cycle).
//  Issue count and receive count are independent; total = K3_WORDS + (k1_en?K1_WORDS:0).
//  Receive counter drives wr_addr: sel=0, idx=n for n<K3_WORDS; then sel=1, idx=n-K3_WORDS.
//  wr_en is combinational from rsp handshake (0-cycle latency rsp->write).
//  done asserts the cycle the final response is accepted is registered (1 cycle later); busy falls same cycle.
//  start while busy: ignored, latched fields unchanged. start same cycle as done: accepted.
//  rsp_vld while IDLE: rsp_rdy=0, no write, no counter change.
//  Reset mid-operation: return to IDLE immediately; in-flight responses are dropped.
// TESTING
//  T1 out_ch=2,w3_base=0x1000,k1_en=1,req_rdy=1,rsp 1-cycle lag -> first addr 0x1240; 80 writes; 73rd wr_addr sel=1 idx=0; one done pulse.
//  T2 k1_en=0,out_ch=0 -> exactly 72 requests 0x1000..0x111C, no sel=1 write, done after 72nd response.
//  T3 req_rdy held 0 for 5 cycles mid-fetch -> req_vld/req_addr stable; no duplicate or skipped address.
//  T4 rsp withheld, req_rdy=1 -> exactly MAX_OUTST=4 issued then req_vld=0; resumes after 1st response.
//  T5 start pulsed while busy, out_ch changed to 9 -> ignored; wr_addr out_ch stays original.
//  T6 rst_n low after 30 responses, then rsp_vld=1 -> wr_en=0, busy=0, new start refetches from word 0.

Source files
------------

// File: rtl/weight_fetch_unit.sv
// weight_fetch_unit: per start, streams one output channel's 3x3 weight block
// (and optionally its 1x1 block) from the memory arbiter into the MAC weight
// buffer, keeping up to MAX_OUTST reads in flight.
module weight_fetch_unit #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int K3_WORDS  = 72,
  parameter int K1_WORDS  = 8,
  parameter int MAX_OUTST = 4,
  parameter int IDX_W     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              k1_en,
  input  logic [7:0]        out_ch,
  input  logic [ADDR_W-1:0] w3_base,
  input  logic [ADDR_W-1:0] w1_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_vld,
  input  logic              req_rdy,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_vld,
  output logic              rsp_rdy,
  output logic              wr_en,
  output logic [8+IDX_W:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = IDX_W + 1;  // word counters span both blocks
  localparam int OST_W = 4;          // MAX_OUTST is at most 15

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ3  = 2'd1;
  localparam logic [1:0] REQ1  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              k1_en_q, k1_en_d;
  logic [7:0]        out_ch_q, out_ch_d;
  logic [ADDR_W-1:0] base3_q, base3_d;   // channel-offset 3x3 base
  logic [ADDR_W-1:0] base1_q, base1_d;   // channel-offset 1x1 base
  logic [CNT_W-1:0]  iss_q, iss_d;       // requests handshaken
  logic [CNT_W-1:0]  rcv_q, rcv_d;       // responses accepted
  logic [OST_W-1:0]  ost_q, ost_d;       // issued but unanswered
  logic              req_vld_q, req_vld_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              done_q, done_d;

  logic              req_hs;
  logic              rsp_hs;
  logic [CNT_W-1:0]  total;
  logic              wr_sel;
  logic [CNT_W-1:0]  wr_idx;

  // Byte address of linear word n: 3x3 words first, then 1x1 words.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [CNT_W-1:0] n);
    if (n < CNT_W'(K3_WORDS))
      return base3_q + ADDR_W'(n) * ADDR_W'(BPW);
    else
      return base1_q + ADDR_W'(n - CNT_W'(K3_WORDS)) * ADDR_W'(BPW);
  endfunction

  assign busy    = (state_q != IDLE);
  assign rsp_rdy = busy;
  assign req_hs  = req_vld_q & req_rdy;
  assign rsp_hs  = rsp_vld & busy;
  assign total   = k1_en_q ? CNT_W'(K3_WORDS + K1_WORDS) : CNT_W'(K3_WORDS);

  assign req_vld  = req_vld_q;
  assign req_addr = req_addr_q;
  assign done     = done_q;

  // Write port: the receive counter decodes into {sel, out_ch, word_idx}.
  assign wr_en   = rsp_hs;
  assign wr_data = rsp_data;
  assign wr_sel  = (rcv_q >= CNT_W'(K3_WORDS));
  assign wr_idx  = wr_sel ? (rcv_q - CNT_W'(K3_WORDS)) : rcv_q;
  assign wr_addr = {wr_sel, out_ch_q, wr_idx[IDX_W-1:0]};

  // Next-state logic: start latch, counters, request pacing and FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    k1_en_d    = k1_en_q;
    out_ch_d   = out_ch_q;
    base3_d    = base3_q;
    base1_d    = base1_q;
    iss_d      = iss_q;
    rcv_d      = rcv_q;
    ost_d      = ost_q;
    req_vld_d  = req_vld_q;
    req_addr_d = req_addr_q;
    done_d     = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        state_d    = REQ3;
        k1_en_d    = k1_en;
        out_ch_d   = out_ch;
        base3_d    = w3_base + ADDR_W'(out_ch) * ADDR_W'(K3_WORDS * BPW);
        base1_d    = w1_base + ADDR_W'(out_ch) * ADDR_W'(K1_WORDS * BPW);
        iss_d      = '0;
        rcv_d      = '0;
        ost_d      = '0;
        req_vld_d  = 1'b1;
        req_addr_d = w3_base + ADDR_W'(out_ch) * ADDR_W'(K3_WORDS * BPW);
      end
    end else begin
      iss_d = iss_q + CNT_W'(req_hs);
      rcv_d = rcv_q + CNT_W'(rsp_hs);
      ost_d = ost_q + OST_W'(req_hs) - OST_W'(rsp_hs);

      // A pending request stays put until the arbiter takes it.
      if (!(req_vld_q && !req_rdy)) begin
        req_vld_d  = (iss_d < total) && (ost_d < OST_W'(MAX_OUTST));
        req_addr_d = word_addr(iss_d);
      end

      if (state_q == REQ3 && req_hs && iss_q == CNT_W'(K3_WORDS - 1))
        state_d = k1_en_q ? REQ1 : DRAIN;
      else if (state_q == REQ1 && req_hs && iss_q == total - CNT_W'(1))
        state_d = DRAIN;

      if (rsp_hs && rcv_q == total - CNT_W'(1)) begin
        state_d   = IDLE;
        req_vld_d = 1'b0;
        done_d    = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k1_en_q    <= 1'b0;
      out_ch_q   <= '0;
      base3_q    <= '0;
      base1_q    <= '0;
      iss_q      <= '0;
      rcv_q      <= '0;
      ost_q      <= '0;
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q    <= state_d;
      k1_en_q    <= k1_en_d;
      out_ch_q   <= out_ch_d;
      base3_q    <= base3_d;
      base1_q    <= base1_d;
      iss_q      <= iss_d;
      rcv_q      <= rcv_d;
      ost_q      <= ost_d;
      req_vld_q  <= req_vld_d;
      req_addr_q <= req_addr_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Self-checking bench for weight_fetch_unit: a randomized arbiter/memory
// model with an address/write scoreboard derived from the block layout.
module tb_weight_fetch_unit;

  localparam int K3    = 72;
  localparam int K1    = 8;
  localparam int MAXO  = 4;
  localparam int IDX_W = 7;

  logic        clk = 1'b0;
  logic        rst_n, start, k1_en, req_rdy, rsp_vld;
  logic [7:0]  out_ch;
  logic [31:0] w3_base, w1_base, rsp_data;
  logic        busy, done, req_vld, rsp_rdy, wr_en;
  logic [31:0] req_addr, wr_data;
  logic [15:0] wr_addr;

  int vectors = 0;
  int errors  = 0;

  // Fields used by a start issued in the same cycle as a done pulse.
  logic [7:0]  c_oc;
  logic [31:0] c_w3, c_w1;
  logic        c_k1;

  always #5 clk = ~clk;

  weight_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .K3_WORDS(K3), .K1_WORDS(K1),
    .MAX_OUTST(MAXO), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k1_en(k1_en), .out_ch(out_ch),
    .w3_base(w3_base), .w1_base(w1_base), .busy(busy), .done(done),
    .req_addr(req_addr), .req_vld(req_vld), .req_rdy(req_rdy),
    .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Expected byte address of linear word i of a fetch.
  function automatic logic [31:0] exp_addr(input logic [7:0] oc, input logic [31:0] w3,
                                           input logic [31:0] w1, input int i);
    if (i < K3) return w3 + (32'(oc) * 32'(K3) + 32'(i)) * 32'd4;
    else        return w1 + (32'(oc) * 32'(K1) + 32'(i - K3)) * 32'd4;
  endfunction

  // Expected weight-buffer address for the n-th response.
  function automatic logic [15:0] exp_wr(input logic [7:0] oc, input int n);
    if (n < K3) return {1'b0, oc, 7'(n)};
    else        return {1'b1, oc, 7'(n - K3)};
  endfunction

  task automatic run_fetch(input logic [7:0] oc, input logic [31:0] w3, input logic [31:0] w1,
                           input logic k1, input int rdy_pct, input int rsp_pct,
                           input bit stall, input bit withhold, input bit restart,
                           input int abort_n, input bit skip_start, input bit chain);
    int total, issued, writes, last_wr_c, stall_left, hold_cycles;
    int pend[$];
    bit rdy, rsp, prev_vld, prev_hs, withholding, finished, aborted, stall_done;
    logic [31:0] prev_addr, data;
    total = k1 ? K3 + K1 : K3;
    issued = 0; writes = 0; last_wr_c = -10; stall_left = 0; hold_cycles = 0;
    prev_vld = 0; prev_hs = 0; prev_addr = '0; finished = 0; aborted = 0;
    stall_done = 0; withholding = withhold;
    if (!skip_start) begin
      @(negedge clk);
      start = 1'b1; out_ch = oc; w3_base = w3; w1_base = w1; k1_en = k1;
    end
    for (int c = 0; c < 4000 && !finished; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart && c == 5) begin
        start = 1'b1; out_ch = 8'd9; w3_base = $urandom; k1_en = ~k1;
      end
      rdy = (int'($urandom_range(99)) < rdy_pct);
      if (stall && !stall_done && issued >= 10) begin stall_left = 5; stall_done = 1; end
      if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
      rsp = 1'b0;
      if (!withholding && pend.size() > 0)
        if (pend[0] < c && int'($urandom_range(99)) < rsp_pct) rsp = 1'b1;
      data = $urandom;
      req_rdy = rdy; rsp_vld = rsp; rsp_data = data;
      #1;
      if (c == 0) begin
        vectors++;
        if (req_vld !== 1'b1 || busy !== 1'b1) begin
          errors++; $display("FAIL first_req: req_vld=%b busy=%b, expected 1 1", req_vld, busy);
        end
      end
      if (prev_vld && !prev_hs) begin
        vectors++;
        if (req_vld !== 1'b1 || req_addr !== prev_addr) begin
          errors++;
          $display("FAIL req_hold: vld=%b addr=%h, expected 1 %h", req_vld, req_addr, prev_addr);
        end
      end
      if (req_vld === 1'b1) begin
        vectors++;
        if (!(pend.size() < MAXO || rsp)) begin
          errors++; $display("FAIL outst_limit: req_vld=1 with %0d outstanding, max %0d", pend.size(), MAXO);
        end
      end
      if (done === 1'b1) begin
        vectors++;
        if (writes != total || last_wr_c != c - 1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_timing: writes=%0d last_wr=%0d busy=%b at %0d, expected %0d %0d 0",
                   writes, last_wr_c, busy, c, total, c - 1);
        end
        finished = 1;
        if (chain) begin
          start = 1'b1; out_ch = c_oc; w3_base = c_w3; w1_base = c_w1; k1_en = c_k1;
        end
      end else begin
        vectors++;
        if (busy !== 1'b1 || rsp_rdy !== 1'b1) begin
          errors++; $display("FAIL busy: busy=%b rsp_rdy=%b, expected 1 1", busy, rsp_rdy);
        end
      end
      vectors++;
      if (wr_en !== rsp) begin
        errors++; $display("FAIL wr_en: got %b, expected %b", wr_en, rsp);
      end
      if (rsp) begin
        void'(pend.pop_front());
        vectors++;
        if (wr_addr !== exp_wr(oc, writes) || wr_data !== data) begin
          errors++;
          $display("FAIL write[%0d]: addr=%h data=%h, expected %h %h",
                   writes, wr_addr, wr_data, exp_wr(oc, writes), data);
        end
        writes++; last_wr_c = c;
      end
      if (req_vld === 1'b1 && rdy) begin
        vectors++;
        if (issued >= total || req_addr !== exp_addr(oc, w3, w1, issued)) begin
          errors++;
          $display("FAIL req_addr[%0d]: got %h, expected %h (total %0d)",
                   issued, req_addr, exp_addr(oc, w3, w1, issued), total);
        end
        issued++; pend.push_back(c);
      end
      prev_vld = (req_vld === 1'b1); prev_hs = prev_vld && rdy; prev_addr = req_addr;
      if (withholding && pend.size() == MAXO) begin
        hold_cycles++;
        if (hold_cycles == 4) begin
          vectors++;
          if (issued != MAXO || req_vld !== 1'b0) begin
            errors++; $display("FAIL withhold_cap: issued=%0d req_vld=%b, expected %0d 0", issued, req_vld, MAXO);
          end
          withholding = 0;
        end
      end
      if (abort_n > 0 && writes == abort_n) begin aborted = 1; finished = 1; end
    end
    if (!finished) begin
      vectors++; errors++;
      $display("FAIL timeout: %0d of %0d writes seen, expected done", writes, total);
    end
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b0; rsp_vld = 1'b0; req_rdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; rsp_vld = 1'b1; rsp_data = $urandom;
      #1;
      vectors++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || req_vld !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort: wr_en=%b busy=%b req_vld=%b done=%b, expected 0 0 0 0", wr_en, busy, req_vld, done);
      end
      @(negedge clk);
      rsp_vld = 1'b0;
    end else if (finished && !chain) begin
      @(negedge clk);
      req_rdy = 1'b0; rsp_vld = 1'b0;
      #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || req_vld !== 1'b0) begin
        errors++; $display("FAIL post_done: done=%b busy=%b req_vld=%b, expected 0 0 0", done, busy, req_vld);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; k1_en = 1'b0; out_ch = '0; w3_base = '0; w1_base = '0;
    req_rdy = 1'b0; rsp_vld = 1'b0; rsp_data = '0;
    repeat (3) @(negedge clk);
    rsp_vld = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || req_vld !== 1'b0 || rsp_rdy !== 1'b0 ||
        req_addr !== 32'h0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b req_vld=%b rsp_rdy=%b req_addr=%h wr_en=%b, expected all 0",
               busy, done, req_vld, rsp_rdy, req_addr, wr_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_rsp: wr_en=%b busy=%b, expected 0 0", wr_en, busy);
    end
    @(negedge clk);
    rsp_vld = 1'b0;
  endtask

  task automatic test_basic();
    run_fetch(8'd2, 32'h1000, 32'h8000, 1'b1, 100, 100, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_no_k1();
    run_fetch(8'd0, 32'h1000, 32'h2000, 1'b0, 100, 100, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    run_fetch(8'd5, $urandom, $urandom, 1'b1, 100, 80, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_outstanding();
    run_fetch(8'd3, $urandom, $urandom, 1'b1, 100, 100, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_busy_start();
    run_fetch(8'd4, $urandom, $urandom, 1'b1, 70, 70, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    run_fetch(8'd6, a, b, 1'b1, 90, 90, 0, 0, 0, 30, 0, 0);
    run_fetch(8'd6, a, b, 1'b1, 90, 90, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    c_oc = 8'd200; c_w3 = $urandom; c_w1 = $urandom; c_k1 = 1'b1;
    run_fetch(8'd17, $urandom, $urandom, 1'b0, 100, 100, 0, 0, 0, 0, 0, 1);
    run_fetch(c_oc, c_w3, c_w1, c_k1, 100, 100, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic [31:0] a;
      a = (n == 0) ? 32'hFFFF_FF00 : $urandom;
      run_fetch(8'($urandom), a, $urandom, 1'($urandom), int'($urandom_range(100, 30)),
                int'($urandom_range(100, 30)), 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_k1();
    test_stall();
    test_outstanding();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
